// File: rtl/segmented_crc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : segmented_crc_ctrl_if
// Brief    : Bundle of requester, datapath and result signals around the
//            segmented CRC frame controller.
//            master = controller side, slave = requesters/datapath/consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface segmented_crc_ctrl_if #(
  parameter int N     = 16,
  parameter int LEN_W = 8
);
  // Requester 0
  logic             req0_valid;
  logic [N-1:0]     req0_data;
  logic             req0_last;
  logic             req0_ready;
  // Requester 1
  logic             req1_valid;
  logic [N-1:0]     req1_data;
  logic             req1_last;
  logic             req1_ready;
  // Shared CRC datapath
  logic             crc_clr;
  logic             crc_en;
  logic [N-1:0]     crc_data;
  logic [N-1:0]     crc_result;
  // Result channel
  logic             res_valid;
  logic             res_ready;
  logic [N-1:0]     res_data;
  logic             res_src;
  logic [LEN_W-1:0] res_len;

  modport master (
    input  req0_valid, req0_data, req0_last,
    input  req1_valid, req1_data, req1_last,
    input  crc_result, res_ready,
    output req0_ready, req1_ready,
    output crc_clr, crc_en, crc_data,
    output res_valid, res_data, res_src, res_len
  );

  modport slave (
    output req0_valid, req0_data, req0_last,
    output req1_valid, req1_data, req1_last,
    output crc_result, res_ready,
    input  req0_ready, req1_ready,
    input  crc_clr, crc_en, crc_data,
    input  res_valid, res_data, res_src, res_len
  );
endinterface
`default_nettype wire

// File: rtl/segmented_crc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : segmented_crc_ctrl
// Brief    : Frame controller and round-robin arbiter for the shared segmented
//            CRC datapath. Grants one requester per frame, clears the datapath,
//            streams words, waits out the pipeline latency and returns the CRC
//            with source ID and saturating word count.
// Revision : 1.0 - initial release
// ============================================================================
module segmented_crc_ctrl #(
  parameter int N     = 16,
  parameter int LAT   = 3,
  parameter int LEN_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  segmented_crc_ctrl_if.master bus,
  output logic                 busy_o
);

  // Drain counter must hold the value LAT
  localparam int DRAIN_W = $clog2(LAT + 1);
  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_STREAM = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0]         state_q, state_d;
  logic               src_q, src_d;
  logic               rr_q, rr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [N-1:0]       hold_q, hold_d;
  logic [N-1:0]       res_data_q, res_data_d;
  logic               res_src_q, res_src_d;
  logic [LEN_W-1:0]   res_len_q, res_len_d;

  logic               any_req;
  logic               grant_pick;
  logic               gnt_valid;
  logic               gnt_last;
  logic [N-1:0]       gnt_data;
  logic               accept;

  assign any_req    = bus.req0_valid | bus.req1_valid;
  // On a tie the round-robin pointer names the winner; otherwise the lone requester wins
  assign grant_pick = (bus.req0_valid & bus.req1_valid) ? rr_q : bus.req1_valid;
  assign gnt_valid  = src_q ? bus.req1_valid : bus.req0_valid;
  assign gnt_last   = src_q ? bus.req1_last  : bus.req0_last;
  assign gnt_data   = src_q ? bus.req1_data  : bus.req0_data;
  assign accept     = (state_q == S_STREAM) & gnt_valid;

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (any_req) state_d = S_CLR;
      S_CLR:    state_d = S_STREAM;
      S_STREAM: if (accept && gnt_last) state_d = S_DRAIN;
      S_DRAIN:  if (drain_q == DRAIN_W'(1)) state_d = S_DONE;
      S_DONE:   if (bus.res_ready) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Handshake and datapath control outputs decoded from the current state
  always_comb begin
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.crc_clr    = 1'b0;
    bus.crc_en     = 1'b0;
    bus.res_valid  = 1'b0;
    case (state_q)
      S_CLR:    bus.crc_clr = 1'b1;
      S_STREAM: begin
        bus.req0_ready = ~src_q;
        bus.req1_ready = src_q;
        bus.crc_en     = gnt_valid;
      end
      S_DONE:   bus.res_valid = 1'b1;
      default:  ;
    endcase
    // Live word while accepting, otherwise the last word handed over
    bus.crc_data = accept ? gnt_data : hold_q;
  end

  assign busy_o       = (state_q != S_IDLE);
  assign bus.res_data = res_data_q;
  assign bus.res_src  = res_src_q;
  assign bus.res_len  = res_len_q;

  // Next values for grant, counters and result capture
  always_comb begin
    src_d      = src_q;
    rr_d       = rr_q;
    cnt_d      = cnt_q;
    drain_d    = drain_q;
    hold_d     = hold_q;
    res_data_d = res_data_q;
    res_src_d  = res_src_q;
    res_len_d  = res_len_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          src_d = grant_pick;
          cnt_d = '0;
        end
      end
      S_STREAM: begin
        if (accept) begin
          hold_d = gnt_data;
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + LEN_W'(1);
          if (gnt_last) drain_d = DRAIN_W'(LAT);
        end
      end
      S_DRAIN: begin
        drain_d = drain_q - DRAIN_W'(1);
        // Last word has now propagated through the datapath pipeline
        if (drain_q == DRAIN_W'(1)) begin
          res_data_d = bus.crc_result;
          res_len_d  = cnt_q;
          res_src_d  = src_q;
        end
      end
      S_DONE: begin
        if (bus.res_ready) rr_d = ~res_src_q;
      end
      default: ;
    endcase
  end

  // Grant, counter and result registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      src_q      <= 1'b0;
      rr_q       <= 1'b0;
      cnt_q      <= '0;
      drain_q    <= '0;
      hold_q     <= '0;
      res_data_q <= '0;
      res_src_q  <= 1'b0;
      res_len_q  <= '0;
    end else begin
      src_q      <= src_d;
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      hold_q     <= hold_d;
      res_data_q <= res_data_d;
      res_src_q  <= res_src_d;
      res_len_q  <= res_len_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_segmented_crc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_segmented_crc_ctrl
// Brief    : Self-checking bench for segmented_crc_ctrl with a CRC datapath
//            model of latency LAT and a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_segmented_crc_ctrl;
  localparam int N     = 16;
  localparam int LAT   = 3;
  localparam int LEN_W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic busy, busy2;
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  segmented_crc_ctrl_if #(.N(N), .LEN_W(LEN_W)) bus ();
  segmented_crc_ctrl_if #(.N(N), .LEN_W(2))     bus2 ();

  segmented_crc_ctrl #(.N(N), .LAT(LAT), .LEN_W(LEN_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus), .busy_o(busy));
  segmented_crc_ctrl #(.N(N), .LAT(LAT), .LEN_W(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus2), .busy_o(busy2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // CRC-16 (poly 0x1021), one N-bit word, MSB first
  function automatic logic [15:0] crc_word(input logic [15:0] c, input logic [15:0] d);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int b = 15; b >= 0; b--) begin
      fb = r[15] ^ d[b];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // Datapath models: accumulate, then two extra stages -> LAT = 3
  logic [15:0] dp_acc = '0, dp_p1 = '0, dp_p2 = '0;
  logic [15:0] dq_acc = '0, dq_p1 = '0, dq_p2 = '0;
  always @(posedge clk) begin
    if (bus.crc_clr) dp_acc <= '0;
    else if (bus.crc_en) dp_acc <= crc_word(dp_acc, bus.crc_data);
    dp_p1 <= dp_acc;
    dp_p2 <= dp_p1;
  end
  always @(posedge clk) begin
    if (bus2.crc_clr) dq_acc <= '0;
    else if (bus2.crc_en) dq_acc <= crc_word(dq_acc, bus2.crc_data);
    dq_p1 <= dq_acc;
    dq_p2 <= dq_p1;
  end
  assign bus.crc_result  = dp_p2;
  assign bus2.crc_result = dq_p2;

  // Reference state and observation
  logic [15:0] frame_q[$];
  logic [15:0] en_q[$];
  int          gap_q[$];
  int          clr_cnt = 0;
  int          clr_cyc = -1;
  logic [15:0] last_en = '0;
  bit          hold_bad = 0;
  bit          rr_model = 0;
  bit          f_to, f_other_rdy, f_rv_to;
  int          f_req_cyc, f_first, f_last, f_rv_cyc, f_cons_cyc;

  initial forever begin
    @(negedge clk);
    #3;
    if (!rst_n) last_en = '0;
    else if (bus.crc_en) begin
      en_q.push_back(bus.crc_data);
      last_en = bus.crc_data;
    end else if (bus.crc_data !== last_en) hold_bad = 1;
    if (bus.crc_clr) begin
      clr_cnt++;
      clr_cyc = cyc;
    end
  end

  function automatic logic [15:0] crc_of();
    logic [15:0] c;
    c = '0;
    foreach (frame_q[i]) c = crc_word(c, frame_q[i]);
    return c;
  endfunction

  function automatic bit same_words();
    if (en_q.size() != frame_q.size()) return 0;
    foreach (frame_q[i]) if (en_q[i] !== frame_q[i]) return 0;
    return 1;
  endfunction

  task automatic fill_frame(input int n);
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(16'($urandom));
  endtask

  task automatic set_req(input bit who, input bit v, input logic [15:0] d, input bit last);
    if (who) begin
      bus.req1_valid = v; bus.req1_data = d; bus.req1_last = last;
    end else begin
      bus.req0_valid = v; bus.req0_data = d; bus.req0_last = last;
    end
  endtask

  // Drives frame_q from one requester, starting at a falling edge; bubbles from gap_q or random
  task automatic drive_frame(input bit who, input int bub_pct);
    int i, gap, guard;
    bit v;
    i = 0; gap = 0; guard = 0;
    f_to = 0; f_other_rdy = 0; f_req_cyc = cyc; f_first = -1; f_last = -1;
    while (i < frame_q.size() && !f_to) begin
      v = (i == 0) || (gap == 0);
      if (v) set_req(who, 1'b1, frame_q[i], i == frame_q.size() - 1);
      else   set_req(who, 1'b0, 16'($urandom), 1'($urandom_range(0, 1)));
      #1;
      if (who ? bus.req0_ready : bus.req1_ready) f_other_rdy = 1;
      if (v && (who ? bus.req1_ready : bus.req0_ready)) begin
        if (i == 0) f_first = cyc;
        if (i == frame_q.size() - 1) f_last = cyc;
        i++;
        if (i < gap_q.size()) gap = gap_q[i];
        else if (bub_pct > 0 && int'($urandom_range(0, 99)) < bub_pct) gap = int'($urandom_range(1, 3));
        else gap = 0;
      end else if (!v) gap--;
      guard++;
      if (guard > 500) f_to = 1;
      @(negedge clk);
    end
    set_req(who, 1'b0, '0, 1'b0);
  endtask

  task automatic wait_result();
    f_rv_to = 1; f_rv_cyc = -1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (bus.res_valid) begin
        f_rv_to = 0; f_rv_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic consume();
    bus.res_ready = 1'b1;
    f_cons_cyc = cyc;
    @(negedge clk);
    bus.res_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, bus.req0_ready, bus.req1_ready, bus.crc_clr, bus.crc_en, bus.res_valid, bus.res_src} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b required 0000000", {busy, bus.req0_ready, bus.req1_ready, bus.crc_clr, bus.crc_en, bus.res_valid, bus.res_src});
    end
    checks++;
    if ({bus.crc_data, bus.res_data, bus.res_len} !== '0) begin
      errors++; $display("FAIL reset_data: got %h required 0", {bus.crc_data, bus.res_data, bus.res_len});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rr_model = 0;
    @(negedge clk);
  endtask

  task automatic test_single_frame();
    int c0;
    frame_q = {16'h0001, 16'h1234, 16'hBEEF};
    gap_q.delete(); en_q.delete(); c0 = clr_cnt;
    drive_frame(0, 0);
    wait_result();
    checks++;
    if (clr_cyc !== f_req_cyc + 1 || clr_cnt - c0 != 1) begin
      errors++; $display("FAIL single_clr: got cycle %0d pulses %0d required cycle %0d pulses 1", clr_cyc, clr_cnt - c0, f_req_cyc + 1);
    end
    checks++;
    if (f_first !== f_req_cyc + 2) begin
      errors++; $display("FAIL single_first_ready: got %0d required %0d", f_first, f_req_cyc + 2);
    end
    checks++;
    if (!same_words()) begin
      errors++; $display("FAIL single_en_words: got %0d words required 3", en_q.size());
    end
    checks++;
    if (f_rv_to || f_rv_cyc !== f_last + LAT + 1) begin
      errors++; $display("FAIL single_latency: got %0d required %0d", f_rv_cyc, f_last + LAT + 1);
    end
    checks++;
    if ({bus.res_src, bus.res_len, bus.res_data} !== {1'b0, 8'd3, crc_of()}) begin
      errors++; $display("FAIL single_result: got src %0d len %0d crc %h required src 0 len 3 crc %h", bus.res_src, bus.res_len, bus.res_data, crc_of());
    end
    consume();
    rr_model = 1;
  endtask

  task automatic test_arbitration();
    logic [15:0] f1[$];
    test_reset();
    f1 = {16'($urandom), 16'($urandom)};
    fill_frame(2);
    set_req(1, 1'b1, f1[0], 1'b0);
    drive_frame(0, 0);
    wait_result();
    checks++;
    if (f_to || f_other_rdy || bus.res_src !== 1'b0 || bus.res_data !== crc_of()) begin
      errors++; $display("FAIL arb_tie_first: got src %0d other_ready %0d required src 0 other_ready 0", bus.res_src, f_other_rdy);
    end
    consume();
    frame_q = f1;
    drive_frame(1, 0);
    wait_result();
    checks++;
    if (clr_cyc !== f_cons_cyc + 2) begin
      errors++; $display("FAIL arb_regrant_clr: got %0d required %0d", clr_cyc, f_cons_cyc + 2);
    end
    checks++;
    if (f_to || bus.res_src !== 1'b1 || bus.res_data !== crc_of()) begin
      errors++; $display("FAIL arb_second: got src %0d crc %h required src 1 crc %h", bus.res_src, bus.res_data, crc_of());
    end
    consume();
    fill_frame(2);
    set_req(1, 1'b1, 16'($urandom), 1'b0);
    drive_frame(0, 0);
    set_req(1, 1'b0, '0, 1'b0);
    wait_result();
    checks++;
    if (f_to || f_other_rdy || bus.res_src !== 1'b0) begin
      errors++; $display("FAIL arb_alternate: got src %0d timeout %0d required src 0", bus.res_src, f_to);
    end
    consume();
    rr_model = 1;
  endtask

  task automatic test_bubbles();
    fill_frame(3);
    gap_q = {0, 2, 0};
    en_q.delete(); hold_bad = 0;
    drive_frame(0, 0);
    gap_q.delete();
    wait_result();
    checks++;
    if (!same_words() || f_last - f_first != 4) begin
      errors++; $display("FAIL bubble_en: got %0d words span %0d required 3 words span 4", en_q.size(), f_last - f_first);
    end
    checks++;
    if (bus.res_len !== 8'd3 || bus.res_data !== crc_of()) begin
      errors++; $display("FAIL bubble_result: got len %0d crc %h required len 3 crc %h", bus.res_len, bus.res_data, crc_of());
    end
    checks++;
    if (hold_bad) begin
      errors++; $display("FAIL bubble_data_hold: got changed crc_data while idle required held value");
    end
    consume();
    rr_model = 1;
  endtask

  task automatic test_hold_result();
    logic [15:0] exp_crc;
    fill_frame(2);
    drive_frame(0, 0);
    exp_crc = crc_of();
    wait_result();
    fill_frame(3);
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({bus.res_valid, bus.res_src, bus.res_len, bus.res_data, bus.req0_ready, bus.req1_ready} !== {1'b1, 1'b0, 8'd2, exp_crc, 2'b00}) begin
        errors++; $display("FAIL hold_stable: got v %0d src %0d len %0d crc %h rdy %b%b required 1 0 2 %h 00", bus.res_valid, bus.res_src, bus.res_len, bus.res_data, bus.req0_ready, bus.req1_ready, exp_crc);
      end
      if (k == 0) set_req(1, 1'b1, frame_q[0], 1'b0);
      @(negedge clk);
      #1;
    end
    consume();
    en_q.delete();
    drive_frame(1, 0);
    wait_result();
    checks++;
    if (clr_cyc !== f_cons_cyc + 2 || bus.res_src !== 1'b1 || bus.res_data !== crc_of()) begin
      errors++; $display("FAIL hold_next_grant: got clr %0d src %0d required clr %0d src 1", clr_cyc, bus.res_src, f_cons_cyc + 2);
    end
    consume();
    rr_model = 0;
  endtask

  task automatic test_reset_midstream();
    int acc, c0;
    bit saw_rv;
    acc = 0;
    fill_frame(5);
    bus.req0_valid = 1'b1; bus.req0_last = 1'b0;
    for (int g = 0; g < 20 && acc < 2; g++) begin
      bus.req0_data = frame_q[acc];
      #1;
      if (bus.req0_ready) acc++;
      @(negedge clk);
    end
    bus.req0_data = frame_q[2];
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (acc != 2 || {busy, bus.req0_ready, bus.req1_ready, bus.crc_clr, bus.crc_en, bus.res_valid, bus.res_src} !== 7'b0
        || {bus.crc_data, bus.res_data, bus.res_len} !== '0) begin
      errors++; $display("FAIL midreset_outputs: got accepted %0d busy %0d en %0d data %h required 2 0 0 0", acc, busy, bus.crc_en, bus.crc_data);
    end
    bus.req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rr_model = 0;
    saw_rv = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (bus.res_valid) saw_rv = 1;
      @(negedge clk);
    end
    checks++;
    if (saw_rv) begin
      errors++; $display("FAIL midreset_no_result: got res_valid 1 required 0");
    end
    fill_frame(3);
    en_q.delete(); c0 = clr_cnt;
    drive_frame(0, 0);
    wait_result();
    checks++;
    if (clr_cnt - c0 != 1 || bus.res_len !== 8'd3 || bus.res_data !== crc_of()) begin
      errors++; $display("FAIL midreset_clean_frame: got clr %0d len %0d crc %h required 1 3 %h", clr_cnt - c0, bus.res_len, bus.res_data, crc_of());
    end
    consume();
    rr_model = 1;
  endtask

  task automatic test_random();
    hold_bad = 0;
    for (int f = 0; f < 12; f++) begin
      bit who, tie, win;
      int n;
      n   = (f == 0) ? 1 : int'($urandom_range(1, 6));
      who = 1'($urandom_range(0, 1));
      tie = ($urandom_range(0, 2) == 0);
      win = tie ? rr_model : who;
      fill_frame(n);
      en_q.delete();
      if (tie) set_req(!win, 1'b1, 16'($urandom), 1'($urandom_range(0, 1)));
      drive_frame(win, 30);
      if (tie) set_req(!win, 1'b0, '0, 1'b0);
      wait_result();
      checks++;
      if (f_to || f_rv_to || !same_words() || f_rv_cyc !== f_last + LAT + 1) begin
        errors++; $display("FAIL rand_stream[%0d]: got timeout %0d/%0d words %0d rv %0d required words %0d rv %0d", f, f_to, f_rv_to, en_q.size(), f_rv_cyc, n, f_last + LAT + 1);
      end
      checks++;
      if ({bus.res_src, bus.res_len, bus.res_data} !== {win, 8'(n), crc_of()}) begin
        errors++; $display("FAIL rand_result[%0d]: got src %0d len %0d crc %h required src %0d len %0d crc %h", f, bus.res_src, bus.res_len, bus.res_data, win, n, crc_of());
      end
      consume();
      rr_model = !win;
    end
    checks++;
    if (hold_bad) begin
      errors++; $display("FAIL rand_data_hold: got changed crc_data while idle required held value");
    end
  endtask

  task automatic test_len_sat();
    int i;
    bit found;
    i = 0; found = 0;
    fill_frame(6);
    bus2.req0_valid = 1'b1;
    for (int g = 0; g < 40 && i < 6; g++) begin
      bus2.req0_data = frame_q[i];
      bus2.req0_last = (i == 5);
      #1;
      if (bus2.req0_ready) i++;
      @(negedge clk);
    end
    bus2.req0_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (bus2.res_valid) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (i != 6 || !found || bus2.res_len !== 2'd3) begin
      errors++; $display("FAIL sat_len: got words %0d valid %0d len %0d required 6 1 3", i, found, bus2.res_len);
    end
    checks++;
    if (bus2.res_data !== crc_of()) begin
      errors++; $display("FAIL sat_crc: got %h required %h", bus2.res_data, crc_of());
    end
    bus2.res_ready = 1'b1;
    @(negedge clk);
    bus2.res_ready = 1'b0;
  endtask

  initial begin
    bus.req0_valid = 0; bus.req0_data = '0; bus.req0_last = 0;
    bus.req1_valid = 0; bus.req1_data = '0; bus.req1_last = 0;
    bus.res_ready  = 0;
    bus2.req0_valid = 0; bus2.req0_data = '0; bus2.req0_last = 0;
    bus2.req1_valid = 0; bus2.req1_data = '0; bus2.req1_last = 0;
    bus2.res_ready  = 0;
    test_reset();
    test_single_frame();
    test_arbitration();
    test_bubbles();
    test_hold_result();
    test_reset_midstream();
    test_random();
    test_len_sat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required finish within 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/segmented_crc_ctrl.md
# segmented_crc_ctrl

Frame-level controller and two-requester arbiter for the segmented CRC datapath (stride-by-5 CRC, computing module, go-back pipeline). It grants the shared datapath to one requester for a whole frame and clears the datapath at frame start. It streams the frame's N-bit words in with a valid/ready handshake, waits out the datapath pipeline latency, then captures the CRC and returns it with source ID and word count.

## Interface
- N, 16, data/CRC word width
- LAT, 3, cycles from a crc_en word at the datapath input to its effect appearing on crc_result (min 1)
- LEN_W, 8, width of frame word counter
- Clk  input  1  single clock, rising edge
- Rst  input  1  reset, asynchronous, active-low
- req0_valid / req1_valid  input  1  requester word valid
- req0_data / req1_data  input  N  requester word
- req0_last / req1_last  input  1  word is last of frame
- req0_ready / req1_ready  output  1  word accepted when valid&ready
- crc_clr  output  1  one-cycle clear pulse to datapath
- crc_en  output  1  crc_data is a valid datapath input this cycle
- crc_data  output  N  word to datapath
- crc_result  input  N  datapath CRC output
- res_valid  output  1  result available
- res_ready  input  1  consumer accepts result
- res_data  output  N  captured CRC
- res_src  output  1  source of the frame (0/1)
- res_len  output  LEN_W  words in frame, saturating
- busy  output  1  state != IDLE

## Operation
- States: IDLE, CLR, STREAM, DRAIN, DONE.
- IDLE: if exactly one reqX_valid, grant X. If both, grant the source not served last (rr pointer; pointer = 0 after reset, so req0 wins first tie). Latch src, clear count, go to CLR. Requesters' ready = 0.
- CLR: crc_clr = 1 for this single cycle. Next state STREAM.
- STREAM: ready of granted source = 1, other = 0. crc_en = granted valid & ready. crc_data = granted data (combinational pass-through). Each accepted word increments count, saturating at 2^LEN_W-1. Accepted word with last = 1 loads drain counter with LAT and goes to DRAIN. Bubbles (valid low) give crc_en = 0; state holds.
- DRAIN: ready = 0, crc_en = 0. Counter decrements each cycle. On the cycle it reaches 1, capture crc_result into res_data, count into res_len, src into res_src, and go to DONE.
- DONE: res_valid = 1; res_data/res_src/res_len stable. When res_ready = 1, go to IDLE and set rr pointer = ~res_src.
- crc_data holds the last driven value when crc_en = 0; only crc_en qualifies it.
- Non-granted requester is never acked; its valid/data may change freely.
- A single-word frame (last on first beat) gives res_len = 1.

## Timing
- Reset (Rst low, any state, async): state IDLE, all ready = 0, crc_clr = 0, crc_en = 0, crc_data = 0, res_valid = 0, res_data = 0, res_src = 0, res_len = 0, busy = 0, rr pointer = 0. An in-flight frame is discarded with no result.
- Request seen in IDLE at cycle t: crc_clr at t+1, ready high from t+2.
- First word is accepted no earlier than t+2, so frame-start latency is 2 cycles.
- Last word accepted at cycle u: crc_result is sampled at the end of cycle u+LAT, and res_valid rises at u+LAT+1.
- Result to next grant: res_ready high at cycle v gives IDLE at v+1. A pending request there is granted at v+1, crc_clr at v+2. Minimum frame-to-frame gap is 3 idle datapath cycles plus LAT.
- res_ready while res_valid = 0 is ignored.
- A request arriving in any non-IDLE state waits; it is not lost as long as the requester holds valid.

## Test plan
- Single frame, req0 sends 0x0001, 0x1234, 0xBEEF (last), LAT = 3 -> crc_clr 1 cycle before first ready; crc_en exactly 3 cycles; res_valid 4 cycles after the last accept; res_len = 3, res_src = 0; res_data equals the datapath model CRC.
- Both valid in IDLE after reset, 2-word frames each -> req0 served first, then req1. With both valid again, req0 is served next (alternation); req1_ready stays 0 throughout req0's frame.
- req0 valid toggles 1,0,0,1,1(last) -> crc_en only on the 3 valid cycles; res_len = 3; CRC matches the gap-free stream.
- res_ready held low 10 cycles in DONE -> res_valid, res_data, res_src, res_len stable; no ready asserted; a new req1 is granted the cycle after res_ready.
- Rst pulsed low mid-STREAM (after 2 of 5 words) -> all outputs 0 immediately; no res_valid; the next frame starts with crc_clr and gives a clean CRC.
- LEN_W = 2, 6-word frame -> res_len saturates at 3; the CRC still covers all 6 words.
